ysyx_24100005_imem_responder: RTL

//   Instruction-memory responder for the core's fetch path: accepts PC fetch requests

---
 rtl/ysyx_24100005_imem_responder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ysyx_24100005_imem_responder.sv
// ysyx_24100005_imem_responder
// Instruction-memory responder for the fetch path. Takes one PC request at a
// time over a valid/ready channel and returns the 32-bit instruction word after
// a programmable latency on a valid/ready response channel. Misaligned or
// out-of-range fetches answer with an ebreak and rsp_err so a runaway PC stops
// the simulation. The array is filled through the ld_* backdoor port.
// Optional build macro IMEM_RAND_DELAY_EN: adds 0..7 extra cycles per request,
// drawn from an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5).
module ysyx_24100005_imem_responder #(
   parameter int unsigned DEPTH   = 1024,
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int unsigned LATENCY = 1,
   localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [31:0]   req_addr,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_inst,
   output logic          rsp_err,
   input  logic          ld_en,
   input  logic [IW-1:0] ld_idx,
   input  logic [31:0]   ld_data
);

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] inst_q, inst_d;
   logic        err_q, err_d;
`ifdef IMEM_RAND_DELAY_EN
   logic [7:0]  lfsr_q, lfsr_d;
`endif

   logic [31:0] mem_q [DEPTH];
   logic [29:0] offWord;
   logic [IW-1:0] rdIdx;
   logic        rdErr;
   logic [31:0] rdWord;

   // Decode the captured address into a word index and an error flag; the
   // array is only consulted when the address is legal.
   always_comb begin
      offWord = 30'((addr_q - BASE) >> 2);
      rdIdx   = offWord[IW-1:0];
      rdErr   = (addr_q[1:0] != 2'b00) || (32'(offWord) >= DEPTH);
      rdWord  = rdErr ? EBREAK : mem_q[rdIdx];
   end

   // Backdoor preload port; the array is not touched by reset.
   always_ff @(posedge clk) begin
      if (ld_en && (32'(ld_idx) < DEPTH)) begin
         mem_q[ld_idx] <= ld_data;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, hold the response in RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      inst_d  = inst_q;
      err_d   = err_q;
`ifdef IMEM_RAND_DELAY_EN
      lfsr_d  = lfsr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               state_d = S_WAIT;
`ifdef IMEM_RAND_DELAY_EN
               cnt_d   = 5'(LATENCY - 1) + {2'b00, lfsr_q[2:0]};
               lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`else
               cnt_d   = 5'(LATENCY - 1);
`endif
            end
         end
         S_WAIT: begin
            if (cnt_q == 5'd0) begin
               state_d = S_RESP;
               inst_d  = rdWord;
               err_d   = rdErr;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and response registers; reset drops any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         addr_q  <= 32'd0;
         inst_q  <= 32'd0;
         err_q   <= 1'b0;
`ifdef IMEM_RAND_DELAY_EN
         lfsr_q  <= 8'hA5;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
`ifdef IMEM_RAND_DELAY_EN
         lfsr_q  <= lfsr_d;
`endif
      end
   end

   // Handshake outputs come straight from the state register; req_ready is
   // also forced low while reset is asserted.
   always_comb begin
      req_ready = rst && (state_q == S_IDLE);
      rsp_valid = (state_q == S_RESP);
      rsp_inst  = inst_q;
      rsp_err   = err_q;
   end

endmodule
